// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first through one
// full-subtractor cell and a borrow flip-flop, then pulses done for one cycle.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, bo;
  logic             accept;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign d  = sa[0] ^ sb[0] ^ br;
  assign bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  // A new request is honoured only from IDLE or DONE; SHIFT ignores start.
  assign accept = start && (state_q != SHIFT);

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state_q == SHIFT) begin
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      sd  <= {d, sd[WIDTH-1:1]};
      br  <= bo;
      cnt <= cnt + 1'b1;
      // Results are published only on completion and held until the next one.
      if (cnt == LAST_CNT) begin
        diff       <= {d, sd[WIDTH-1:1]};
        borrow_out <= bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH = 8); inputs are driven
// and outputs sampled on the falling edge, away from the active rising edge.
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int n_checks = 0;
  int n_errors = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [WIDTH-1:0] exp_diff,
                                    input logic exp_borrow);
    check({tag, " busy"},   32'(busy),       32'd0);
    check({tag, " done"},   32'(done),       32'd0);
    check({tag, " diff"},   32'(diff),       32'(exp_diff));
    check({tag, " borrow"}, 32'(borrow_out), 32'(exp_borrow));
  endtask

  // Counts falling edges from the one after accept until done is seen,
  // tracking busy cycles and any busy/done overlap; bounded by 20 cycles.
  task automatic wait_done(output int lat, output int busy_cycles, output bit overlap);
    lat = 0;
    busy_cycles = 0;
    overlap = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic [WIDTH-1:0] exp_diff, input logic exp_borrow);
    int lat, bc;
    bit ov;
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~op_a;
    b = ~op_b;
    wait_done(lat, bc, ov);
    check({tag, " latency"},     32'(lat),        32'd8);
    check({tag, " busy_cycles"}, 32'(bc),         32'd8);
    check({tag, " overlap"},     32'(ov),         32'd0);
    check({tag, " diff"},        32'(diff),       32'(exp_diff));
    check({tag, " borrow"},      32'(borrow_out), 32'(exp_borrow));
    @(negedge clk);
    check_idle_outputs({tag, " hold"}, exp_diff, exp_borrow);
  endtask

  initial begin
    int lat, bc, gap;
    bit ov;
    bit saw_done;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_outputs("idle", 8'h00, 1'b0);
    end

    run_op("5-3",   8'h05, 8'h03, 8'h02, 1'b0);
    run_op("3-5",   8'h03, 8'h05, 8'hFE, 1'b1);
    run_op("0-1",   8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("a5-a5", 8'hA5, 8'hA5, 8'h00, 1'b0);

    // Second request and operand changes during SHIFT must be ignored.
    a = 8'h80;
    b = 8'h7F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignore latency", 32'(lat),        32'd5);
    check("ignore diff",    32'(diff),       32'h01);
    check("ignore borrow",  32'(borrow_out), 32'd0);
    @(negedge clk);
    check_idle_outputs("ignore hold", 8'h01, 1'b0);

    // Back-to-back with start held high: second op accepted from DONE.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    a = 8'h20;
    b = 8'h02;
    wait_done(lat, bc, ov);
    check("b2b first latency", 32'(lat),  32'd8);
    check("b2b first overlap", 32'(ov),   32'd0);
    check("b2b first diff",    32'(diff), 32'h0F);
    @(negedge clk);
    start = 1'b0;
    check("b2b busy reassert", 32'(busy), 32'd1);
    check("b2b done drop",     32'(done), 32'd0);
    check("b2b diff hold",     32'(diff), 32'h0F);
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b done spacing",   32'(gap),        32'd9);
    check("b2b second diff",    32'(diff),       32'h1E);
    check("b2b second borrow",  32'(borrow_out), 32'd0);
    @(negedge clk);
    check_idle_outputs("b2b hold", 8'h1E, 1'b0);

    // Reset mid-SHIFT discards the operation and clears outputs.
    a = 8'h50;
    b = 8'h20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("mid reset", 8'h00, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("mid reset quiet", 32'(saw_done), 32'd0);
    run_op("50-20", 8'h50, 8'h20, 8'h30, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor. It is the inverse-direction companion to the combinational full-adder cell. It accepts two WIDTH-bit operands on a start strobe and computes `a - b` LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It then presents the difference and final borrow with a one-cycle done pulse. It sits beside the adder datapath in the lab ALU and serves as the small-area subtraction path.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is 2 to 32.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst_n  in  1`: reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `start  in  1`: operation request; sampled only in states IDLE and DONE.
- `a  in  WIDTH`: minuend, unsigned; captured on the accepting edge only.
- `b  in  WIDTH`: subtrahend, unsigned; captured on the accepting edge only.
- `busy  out  1`: high while in state SHIFT.
- `done  out  1`: high for exactly one cycle, in state DONE.
- `diff  out  WIDTH`: registered result `(a - b) mod 2^WIDTH`.
- `borrow_out  out  1`: registered final borrow; 1 if and only if `a < b` (unsigned).

## Operation
- **Internal state**
  - Shift registers `sa` and `sb`, each WIDTH bits.
  - Partial-result shift register `sd`, WIDTH bits.
  - Borrow flip-flop `br`.
  - Bit counter `cnt`, `clog2(WIDTH)` bits.
  - FSM with states IDLE, SHIFT, DONE.
- **Full-subtractor cell** (combinational)
  - `d = sa[0] ^ sb[0] ^ br`
  - `bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`
- **IDLE**
  - If `start == 1`: load `sa <= a`, `sb <= b`, `br <= 0`, `cnt <= 0`, then go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**
  - Each edge: `sa` and `sb` shift right by one; `sd` shifts right with `d` inserted at the MSB; `br <= bo`; `cnt <= cnt + 1`.
  - On the edge where `cnt == WIDTH-1`: write `diff <= {d, sd[WIDTH-1:1]}` and `borrow_out <= bo`, then go to DONE.
  - `start` is ignored in SHIFT. Operands captured at accept are not disturbed by later changes on `a` or `b`.
- **DONE**
  - Lasts one cycle.
  - If `start == 1`: accept the new operands exactly as in IDLE and go to SHIFT. This gives back-to-back operation with no idle gap.
  - Otherwise go to IDLE.
- **Output holding**: `diff` and `borrow_out` change only on the SHIFT-to-DONE edge. They hold the last result through IDLE and through any subsequent SHIFT until the next completion.
- **Reset**: on any edge with `rst_n == 0`, regardless of state (including mid-SHIFT):
  - FSM goes to IDLE.
  - `sa`, `sb`, `sd`, `br`, `cnt`, `diff`, `borrow_out` all clear to 0.
  - `busy = 0`, `done = 0`.
  - An operation in progress is discarded with no done pulse.
  - Reset has priority over `start`.

## Timing
- Accept edge E0 is the edge where `start` is sampled high in IDLE or DONE.
- `busy` is high from just after E0 until just after E(WIDTH): exactly WIDTH cycles.
- `done`, `diff` and `borrow_out` become valid just after E(WIDTH), i.e. a latency of WIDTH clocks from accept.
- `done` deasserts after E(WIDTH+1).
- Throughput is one result per WIDTH+1 cycles when `start` is held high continuously.
- `busy` and `done` are never high in the same cycle.
- All outputs are driven from registers or decoded from the registered FSM state only. There are no combinational paths from inputs to outputs.
- Wrap-around: the result is modulo `2^WIDTH`. `borrow_out` is the only indication of underflow.

## Test plan (WIDTH = 8)
- Reset for 2 cycles, then idle for 5 -> `busy = 0`, `done = 0`, `diff = 0x00`, `borrow_out = 0` throughout.
- `a = 0x05`, `b = 0x03`, `start` pulsed one cycle -> `busy` high for 8 cycles; `done` pulses exactly 8 edges after accept; `diff = 0x02`, `borrow_out = 0`; values held afterwards.
- `a = 0x03`, `b = 0x05` -> `diff = 0xFE`, `borrow_out = 1`. Also `a = 0x00`, `b = 0x01` -> `diff = 0xFF`, `borrow_out = 1`. Also `a = b = 0xA5` -> `diff = 0x00`, `borrow_out = 0`.
- Issue `0x80 - 0x7F`, then pulse `start` with `a = 0xFF`, `b = 0x00` at cycle 3 of SHIFT -> second request ignored; result is `diff = 0x01`, `borrow_out = 0`; `a` and `b` input changes mid-operation have no effect.
- `start` held high across two operations (`0x10 - 0x01`, then `0x20 - 0x02`) -> done pulses 9 cycles apart; `diff = 0x0F`, then `0x1E`; `busy` reasserts on the cycle after the first `done`.
- Start `0x50 - 0x20`, assert `rst_n = 0` for one edge at cycle 4 of SHIFT -> next cycle is IDLE with all outputs 0 and no `done` pulse; a fresh `0x50 - 0x20` then completes with `diff = 0x30`.
